// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// ALU control codes, datapath width, FSM states, sign-extend helper.
package mdu_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [4:0] MDU_MUL  = 5'b10001;
  localparam logic [4:0] MDU_DIV  = 5'b10010;
  localparam logic [4:0] MDU_REM  = 5'b10000;
  localparam logic [4:0] MDU_DIVU = 5'b11010;
  localparam logic [4:0] MDU_REMU = 5'b11000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

  function automatic logic [XLEN-1:0] sext32(
    input logic [31:0] v
  );
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration step: shift-add multiply or restoring divide.
// Ports: is_div selects mode; acc/opa/opb in, *_n next values out.
module mdu_iter_core #(
  parameter int XLEN = 64
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc_n,
  output logic [XLEN-1:0] opa_n,
  output logic [XLEN-1:0] opb_n
);

  // Divide: acc = partial remainder, opa = divisor,
  // opb = dividend shifting out / quotient shifting in.
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  always_comb begin
    shl   = {acc, opb[XLEN-1]};
    diff  = shl - {1'b0, opa};
    acc_n = acc;
    opa_n = opa;
    opb_n = opb;
    if (is_div) begin
      if (!diff[XLEN]) begin
        acc_n = diff[XLEN-1:0];
        opb_n = {opb[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shl[XLEN-1:0];
        opb_n = {opb[XLEN-2:0], 1'b0};
      end
    end else begin
      // Multiply: acc += opa when multiplier lsb set.
      acc_n = acc + (opb[0] ? opa : '0);
      opa_n = {opa[XLEN-2:0], 1'b0};
      opb_n = {1'b0, opb[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV64 M-extension sequencer, one bit per cycle.
// Ports: in_* request handshake, out_* result handshake, flush, busy.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN  = mdu_pkg::XLEN,
  parameter int CNT_W = mdu_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  mdu_state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc, opa, opb, res;
  logic             r_mul, r_rem, r_word, r_neg;
  logic [XLEN-1:0]  acc_n, opa_n, opb_n;

  logic            d_ok, d_mul, d_rem, d_sgn;
  logic [XLEN-1:0] a_w, b_w, a_mag, b_mag;
  logic            a_neg, b_neg;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] spec_raw, spec_res;
  logic [XLEN-1:0] min_neg;
  logic [XLEN-1:0] raw, fix, fin;

  always_comb begin
    d_ok  = 1'b0;
    d_mul = 1'b0;
    d_rem = 1'b0;
    d_sgn = 1'b0;
    unique case (1'b1)
      (op == MDU_MUL): begin
        d_ok  = 1'b1;
        d_mul = 1'b1;
        d_sgn = 1'b1;
      end
      (op == MDU_DIV): begin
        d_ok  = 1'b1;
        d_sgn = 1'b1;
      end
      (op == MDU_REM): begin
        d_ok  = 1'b1;
        d_rem = 1'b1;
        d_sgn = 1'b1;
      end
      (op == MDU_DIVU): begin
        d_ok  = 1'b1;
      end
      (op == MDU_REMU): begin
        d_ok  = 1'b1;
        d_rem = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands normalised to the active width, then magnitudes.
  always_comb begin
    if (is_word) begin
      a_w = d_sgn ? sext32(src1[31:0])
                  : {{(XLEN-32){1'b0}}, src1[31:0]};
      b_w = d_sgn ? sext32(src2[31:0])
                  : {{(XLEN-32){1'b0}}, src2[31:0]};
      min_neg = sext32(32'h8000_0000);
    end else begin
      a_w = src1;
      b_w = src2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg = d_sgn & a_w[XLEN-1];
    b_neg = d_sgn & b_w[XLEN-1];
    a_mag = a_neg ? -a_w : a_w;
    b_mag = b_neg ? -b_w : b_w;
    b_zero = (b_w == '0);
    ovf = d_sgn & (a_w == min_neg) & (b_w == '1);
  end

  always_comb begin
    spec_raw = '0;
    if (d_ok && !d_mul) begin
      if (b_zero)
        spec_raw = d_rem ? a_w : '1;
      else if (ovf)
        spec_raw = d_rem ? '0 : a_w;
    end
    spec_res = is_word ? sext32(spec_raw[31:0])
                       : spec_raw;
    special  = !d_ok | (!d_mul & (b_zero | ovf));
  end

  mdu_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .is_div (!r_mul),
    .acc    (acc),
    .opa    (opa),
    .opb    (opb),
    .acc_n  (acc_n),
    .opa_n  (opa_n),
    .opb_n  (opb_n)
  );

  // Word quotient sits in the low half of opb.
  always_comb begin
    if (r_mul || r_rem)
      raw = acc_n;
    else if (r_word)
      raw = {{(XLEN-32){1'b0}}, opb_n[31:0]};
    else
      raw = opb_n;
    fix = r_neg ? -raw : raw;
    fin = r_word ? sext32(fix[31:0]) : fix;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:
          if (in_valid)
            state_n = special ? S_DONE : S_CALC;
        S_CALC:
          if (cnt == CNT_W'(1))
            state_n = S_DONE;
        S_DONE:
          if (out_ready)
            state_n = S_IDLE;
        default:
          state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      r_mul  <= 1'b0;
      r_rem  <= 1'b0;
      r_word <= 1'b0;
      r_neg  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (in_valid) begin
        r_mul  <= d_mul;
        r_rem  <= d_rem;
        r_word <= is_word;
        r_neg  <= d_rem ? a_neg : (a_neg ^ b_neg);
        acc    <= '0;
        if (special) begin
          cnt <= '0;
          res <= spec_res;
        end else begin
          cnt <= is_word ? CNT_W'(32)
                         : CNT_W'(XLEN);
          if (d_mul) begin
            opa <= a_mag;
            opb <= b_mag;
          end else begin
            opa <= b_mag;
            opb <= is_word ? (a_mag << 32) : a_mag;
          end
        end
      end
    end else if (state == S_CALC) begin
      acc <= acc_n;
      opa <= opa_n;
      opb <= opb_n;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1))
        res <= fin;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign result    = res;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer for the RV64 execute stage.
- Takes the M-extension operations that the decoder flags via the ALU control code (mul, div, rem, divu, remu and their W forms). Runs them iteratively, one bit per cycle.
- Uses a valid/ready handshake, so the core stalls the pipeline while the block is busy.
- Sits beside the single-cycle ALU; the writeback mux selects its result when the stall releases.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- op  in  5  ALU control code: 10001 mul, 10010 div, 10000 rem, 11010 divu, 11000 remu
- is_word  in  1  W variant: 32-bit operate, sign-extend result
- src1  in  XLEN  rs1 value (multiplicand / dividend)
- src2  in  XLEN  rs2 value (multiplier / divisor)
- flush  in  1  abort current operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  final value
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port clk, reset port rst.
- Reset: state IDLE. in_ready=1, out_valid=0, result=0, busy=0, counter=0, internal registers 0.
- States:
  - IDLE: in_ready=1. on in_valid, latch op/is_word/operands → CALC, or → DONE for special cases.
  - CALC: counter decrements each cycle; at counter==1 the final step completes → DONE.
  - DONE: out_valid=1 and result held stable until out_ready; out_valid&&out_ready → IDLE.
- Iteration count N:
  - is_word=0: N=64.
  - is_word=1: N=32, operands first truncated to bits[31:0]. Signed ops sign-extend from bit 31; divu/remu zero-extend.
- Latency: accept in cycle 0; CALC cycles 1..N; out_valid first high in cycle N+1. No new request is accepted until return to IDLE (in_ready low in CALC and DONE).
- Multiply:
  - Shift-add of |src1| × |src2|, low XLEN bits kept.
  - Negated when operand signs differ (identical low bits either way, so unsigned math is acceptable).
- Divide/remainder:
  - Restoring division on magnitudes.
  - Signed ops: quotient negated if signs differ; remainder takes the dividend's sign.
- Word result: result = sign-extend(raw[31:0]) for all W ops, including divuw/remuw.
- Special cases, decided in IDLE; they skip CALC and DONE is entered next cycle (out_valid in cycle 1):
  - divisor==0: quotient = all ones (at the active width, then W-extended); remainder = dividend.
  - Signed overflow (most-negative ÷ −1, at the active width): quotient = dividend; remainder = 0.
  - op not in the supported set: result = 0.
- Flush:
  - Any state, next cycle → IDLE, out_valid=0, counter cleared. Any pending result is discarded.
  - flush with in_valid in the same IDLE cycle: request ignored.
- Reset mid-operation: same as flush; all outputs return to reset values.
- Ordering: in_valid is held high and not sampled outside IDLE. out_valid never drops without handshake, flush or rst.

Decomposition:
- Shared package mdu_pkg:
  - ALU control code constants (MDU_MUL, MDU_DIV, MDU_REM, MDU_DIVU, MDU_REMU).
  - XLEN.
  - State enum (S_IDLE, S_CALC, S_DONE).
- One sub-module, mdu_iter_core:
  - Per-cycle shift-add / restore-subtract step on an accumulator+operand pair, selected by a mul/div flag.
  - The FSM, counter, sign fix-up and W extension stay in mdu_seq.

Test Plan:
- mul 7×6, is_word=0 → out_valid first in cycle 65, result=42. Then mul −3×5 → 0xFFFFFFFFFFFFFFF1.
- div −7/2 → −3 (0xFFFFFFFFFFFFFFFD); rem −7,2 → −1; divu 100/7 → 14; remu 100/7 → 2. Each has latency 65.
- divu 5/0 → 0xFFFFFFFFFFFFFFFF in cycle 1; rem 5,0 → 5. div 0x8000000000000000 / −1 → 0x8000000000000000; rem same → 0.
- is_word=1:
  - mulw 0x7FFFFFFF×2 → 0xFFFFFFFFFFFFFFFE, out_valid in cycle 33.
  - divuw 0xFFFFFFFF/1 → 0xFFFFFFFFFFFFFFFF.
  - Upper src bits 0xDEADBEEF must not affect results.
- Backpressure: out_ready=0 for 10 cycles after DONE → out_valid and result stable, in_ready=0. A held in_valid is accepted only after the handshake cycle.
- flush in cycle 20 of a 64-bit div → IDLE next cycle, no out_valid. Next mul 3×3 → 9. rst asserted mid-CALC → all outputs reset values next cycle.
